// File: rtl/saida_pkg.sv
// Shared definitions for the output-unit write path: default sizes,
// requester indices and the buffered write entry.
package saida_pkg;

  localparam int NUM_SAIDAS_PADRAO   = 3;
  localparam int PROFUNDIDADE_PADRAO = 4;

  // Requester indices; also the value loaded into origem_erro.
  localparam logic REQ_CPU   = 1'b0;
  localparam logic REQ_DEBUG = 1'b1;

  // One buffered write: target display address plus data word.
  typedef struct packed {
    logic [31:0] endereco;
    logic [31:0] dado;
  } entrada_t;

endpackage

// File: rtl/fifo_saida.sv
// Small circular-buffer FIFO holding pending display writes for one
// requester. Pointers carry one extra wrap bit so full and empty are
// told apart without a separate counter. The head entry is visible
// combinationally so the arbiter can issue it on the same edge it pops.
module fifo_saida
  import saida_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  entrada_t entrada,
  input  logic     pop,
  output entrada_t cabeca,
  output logic     cheio,
  output logic     vazio
);

  localparam int AW = $clog2(PROFUNDIDADE);

  entrada_t       mem [PROFUNDIDADE];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           push_ok;
  logic           pop_ok;

  // Full when the index bits match but the wrap bits differ.
  assign cheio   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign vazio   = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok = push & ~cheio;
  assign pop_ok  = pop & ~vazio;
  assign cabeca  = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= entrada;
    end
  end

  // Pointer update; reset empties the FIFO and overrides push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/arbitro_saida.sv
// Round-robin write arbiter in front of the output unit. Two requesters
// (CPU and debug/loader) each feed a private FIFO; one head entry is
// granted per cycle, range-checked against the number of displays, and
// either registered onto the output port or dropped with a sticky flag.
module arbitro_saida
  import saida_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int NUM_SAIDAS   = NUM_SAIDAS_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_endereco,
  input  logic [31:0] req0_dado,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_endereco,
  input  logic [31:0] req1_dado,
  output logic        OUT,
  output logic [31:0] endereco,
  output logic [31:0] dado_de_saida,
  output logic        ocupado,
  output logic        erro_endereco,
  output logic        origem_erro
);

  localparam logic [31:0] LIMITE = 32'(NUM_SAIDAS);

  logic [1:0] valid_vec;
  logic [1:0] ready_vec;
  logic [1:0] push_vec;
  logic [1:0] pop_vec;
  logic [1:0] cheio_vec;
  logic [1:0] vazio_vec;
  entrada_t   entrada_vec [2];
  entrada_t   cabeca_vec  [2];

  logic       concede;
  logic       vencedor;
  entrada_t   cabeca;
  logic       endereco_valido;

  logic        out_reg;
  logic [31:0] endereco_reg;
  logic [31:0] dado_reg;
  logic        erro_reg;
  logic        origem_reg;
  logic        ultimo_reg;

  assign valid_vec      = {req1_valid, req0_valid};
  assign entrada_vec[0] = '{endereco: req0_endereco, dado: req0_dado};
  assign entrada_vec[1] = '{endereco: req1_endereco, dado: req1_dado};
  assign req0_ready     = ready_vec[0];
  assign req1_ready     = ready_vec[1];

  // One FIFO per requester; ready depends only on registered occupancy.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      assign ready_vec[gi] = ~cheio_vec[gi];
      assign push_vec[gi]  = valid_vec[gi] & ~cheio_vec[gi];

      fifo_saida #(
        .PROFUNDIDADE(PROFUNDIDADE)
      ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_vec[gi]),
        .entrada (entrada_vec[gi]),
        .pop     (pop_vec[gi]),
        .cabeca  (cabeca_vec[gi]),
        .cheio   (cheio_vec[gi]),
        .vazio   (vazio_vec[gi])
      );
    end
  endgenerate

  // Grant selection: a lone non-empty FIFO wins; on a tie the requester
  // not granted last wins. The granted head is range-checked here.
  always_comb begin
    concede  = 1'b0;
    vencedor = REQ_CPU;
    pop_vec  = 2'b00;
    if (!vazio_vec[0] && !vazio_vec[1]) begin
      concede  = 1'b1;
      vencedor = ~ultimo_reg;
    end else if (!vazio_vec[0]) begin
      concede  = 1'b1;
      vencedor = REQ_CPU;
    end else if (!vazio_vec[1]) begin
      concede  = 1'b1;
      vencedor = REQ_DEBUG;
    end
    if (concede) begin
      pop_vec[vencedor] = 1'b1;
    end
    cabeca          = vencedor ? cabeca_vec[1] : cabeca_vec[0];
    endereco_valido = (cabeca.endereco < LIMITE);
  end

  // Output registers, round-robin pointer and sticky address-error state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_reg      <= 1'b0;
      endereco_reg <= '0;
      dado_reg     <= '0;
      erro_reg     <= 1'b0;
      origem_reg   <= 1'b0;
      ultimo_reg   <= 1'b1;
    end else begin
      out_reg <= 1'b0;
      if (concede) begin
        ultimo_reg <= vencedor;
        if (endereco_valido) begin
          out_reg      <= 1'b1;
          endereco_reg <= cabeca.endereco;
          dado_reg     <= cabeca.dado;
        end else begin
          erro_reg <= 1'b1;
          if (!erro_reg) begin
            origem_reg <= vencedor;
          end
        end
      end
    end
  end

  assign OUT           = out_reg;
  assign endereco      = endereco_reg;
  assign dado_de_saida = dado_reg;
  assign erro_endereco = erro_reg;
  assign origem_erro   = origem_reg;
  assign ocupado       = ~(&vazio_vec) | out_reg;

endmodule

// File: tb/tb_arbitro_saida.sv
// Directed bench for arbitro_saida. Stimulus pushes the hand-derived
// expected output writes into a queue; a forked monitor pops and
// compares on every cycle where OUT is high.
module tb_arbitro_saida;

  logic        clock;
  logic        reset;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_endereco;
  logic [31:0] req0_dado;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_endereco;
  logic [31:0] req1_dado;
  logic        OUT;
  logic [31:0] endereco;
  logic [31:0] dado_de_saida;
  logic        ocupado;
  logic        erro_endereco;
  logic        origem_erro;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } esp_t;

  esp_t fila [$];
  int   total;
  int   bad;
  int   out_cycles;

  arbitro_saida #(
    .PROFUNDIDADE(4),
    .NUM_SAIDAS  (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_endereco (req0_endereco),
    .req0_dado     (req0_dado),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_endereco (req1_endereco),
    .req1_dado     (req1_dado),
    .OUT           (OUT),
    .endereco      (endereco),
    .dado_de_saida (dado_de_saida),
    .ocupado       (ocupado),
    .erro_endereco (erro_endereco),
    .origem_erro   (origem_erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end else begin
      $display("ok   %s: %h", nome, got);
    end
  endtask

  task automatic esperar(input logic [31:0] a, input logic [31:0] d);
    esp_t e;
    e.a = a;
    e.d = d;
    fila.push_back(e);
  endtask

  // Drive one cycle of requests starting just after a rising edge.
  task automatic ciclo(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] d1);
    req0_valid    = v0;
    req0_endereco = a0;
    req0_dado     = d0;
    req1_valid    = v1;
    req1_endereco = a1;
    req1_dado     = d1;
    @(posedge clock);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic espera_ciclos(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic aplica_reset();
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    espera_ciclos(2);
    reset = 1'b1;
  endtask

  // Scoreboard monitor: every OUT-high cycle must match the queue head.
  task automatic monitor();
    esp_t e;
    forever begin
      @(negedge clock);
      if (OUT === 1'b1) begin
        out_cycles++;
        if (fila.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got endereco=%h dado=%h expected no write",
                   endereco, dado_de_saida);
        end else begin
          e = fila.pop_front();
          check("out_endereco", endereco, e.a);
          check("out_dado", dado_de_saida, e.d);
        end
      end
    end
  endtask

  initial begin
    logic r0_seen [10];
    logic r0_exp  [10];
    int   snap;
    int   pa;
    int   pb;
    logic v0;
    logic v1;

    total         = 0;
    bad           = 0;
    out_cycles    = 0;
    reset         = 1'b0;
    req0_valid    = 1'b0;
    req1_valid    = 1'b0;
    req0_endereco = '0;
    req0_dado     = '0;
    req1_endereco = '0;
    req1_dado     = '0;
    fork
      monitor();
    join_none
    espera_ciclos(2);
    reset = 1'b1;

    // Reset while both FIFOs hold two entries: A0 and B0 issue, the rest are lost.
    esperar(32'd0, 32'hA000_0000);
    esperar(32'd0, 32'hB000_0000);
    for (int i = 0; i < 3; i++) begin
      ciclo(1'b1, 32'd0, 32'hA000_0000 + i, 1'b1, 32'd0, 32'hB000_0000 + i);
    end
    reset = 1'b0;
    espera_ciclos(2);
    reset = 1'b1;
    check("rst_out", 32'(OUT), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd1);
    check("rst_ready1", 32'(req1_ready), 32'd1);
    check("rst_endereco", endereco, 32'd0);
    check("rst_dado", dado_de_saida, 32'd0);
    check("rst_erro", 32'(erro_endereco), 32'd0);
    check("rst_origem", 32'(origem_erro), 32'd0);
    espera_ciclos(6);

    // Single CPU write: OUT high for exactly the cycle after the next edge.
    esperar(32'd1, 32'hDEAD_BEEF);
    ciclo(1'b1, 32'd1, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
    check("single_out_n", 32'(OUT), 32'd0);
    espera_ciclos(1);
    check("single_out_n1", 32'(OUT), 32'd1);
    check("single_endereco", endereco, 32'd1);
    check("single_dado", dado_de_saida, 32'hDEAD_BEEF);
    espera_ciclos(1);
    check("single_out_n2", 32'(OUT), 32'd0);
    espera_ciclos(2);

    // Simultaneous bursts of three: strict alternation A0,B0,A1,B1,A2,B2.
    aplica_reset();
    for (int i = 0; i < 3; i++) begin
      esperar(32'(i), 32'h0000_00A0 + i);
      esperar(32'(i), 32'h0000_00B0 + i);
    end
    snap = 0;
    for (int i = 0; i < 3; i++) begin
      ciclo(1'b1, 32'(i), 32'h0000_00A0 + i, 1'b1, 32'(i), 32'h0000_00B0 + i);
      if (i == 1) snap = out_cycles;
    end
    espera_ciclos(5);
    check("burst_no_gaps", 32'(out_cycles - snap), 32'd6);
    check("burst_out_after", 32'(OUT), 32'd0);
    espera_ciclos(2);

    // Five back-to-back CPU writes without contention never fill the FIFO.
    for (int i = 0; i < 5; i++) begin
      check("nocont_ready0", 32'(req0_ready), 32'd1);
      esperar(32'(i % 3), 32'h0000_0040 + i);
      ciclo(1'b1, 32'(i % 3), 32'h0000_0040 + i, 1'b0, 32'd0, 32'd0);
    end
    espera_ciclos(3);

    // Both requesters push eight entries as fast as ready allows.
    aplica_reset();
    for (int i = 0; i < 8; i++) begin
      esperar(32'(i % 3), 32'h0000_0100 + i);
      esperar(32'((i + 1) % 3), 32'h0000_0200 + i);
    end
    r0_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    pa = 0;
    pb = 0;
    for (int k = 0; k < 20; k++) begin
      if (pa >= 8 && pb >= 8) break;
      if (k < 10) r0_seen[k] = req0_ready;
      v0 = req0_ready && (pa < 8);
      v1 = req1_ready && (pb < 8);
      ciclo(v0, 32'(pa % 3), 32'h0000_0100 + pa, v1, 32'((pb + 1) % 3), 32'h0000_0200 + pb);
      if (v0) pa++;
      if (v1) pb++;
    end
    check("cont_pushes0", 32'(pa), 32'd8);
    check("cont_pushes1", 32'(pb), 32'd8);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("cont_ready0_c%0d", k), 32'(r0_seen[k]), 32'(r0_exp[k]));
    end
    espera_ciclos(12);

    // Debug write to addr 3 is dropped and flagged; CPU addr 0 issues.
    aplica_reset();
    ciclo(1'b0, 32'd0, 32'd0, 1'b1, 32'd3, 32'h0000_0033);
    esperar(32'd0, 32'd7);
    ciclo(1'b1, 32'd0, 32'd7, 1'b0, 32'd0, 32'd0);
    espera_ciclos(4);
    check("err_flag", 32'(erro_endereco), 32'd1);
    check("err_origem", 32'(origem_erro), 32'd1);
    ciclo(1'b1, 32'd5, 32'h0000_0055, 1'b0, 32'd0, 32'd0);
    espera_ciclos(4);
    check("err_flag_sticky", 32'(erro_endereco), 32'd1);
    check("err_origem_kept", 32'(origem_erro), 32'd1);

    // High address bits make 0x100 invalid; address 2 is the last valid one.
    aplica_reset();
    ciclo(1'b1, 32'h0000_0100, 32'h0000_0066, 1'b0, 32'd0, 32'd0);
    espera_ciclos(3);
    check("hi_addr_flag", 32'(erro_endereco), 32'd1);
    check("hi_addr_origem", 32'(origem_erro), 32'd0);
    esperar(32'd2, 32'h0000_0077);
    ciclo(1'b1, 32'd2, 32'h0000_0077, 1'b0, 32'd0, 32'd0);
    espera_ciclos(4);
    check("hi_addr_origem_kept", 32'(origem_erro), 32'd0);

    check("scoreboard_drained", 32'(fila.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_saida.md
# arbitro_saida

Round-robin write arbiter and buffer in front of the `saida_de_dados` output unit. It lets two requesters share that unit's single write port (`endereco`, `dado_de_saida`, `OUT`): requester 0 is the CPU OUT path and requester 1 is the debug/loader path. Each requester gets a small FIFO, so a short burst of OUT instructions never stalls the pipeline. Writes to non-existent display addresses are filtered out and flagged.

## Interface
- `PROFUNDIDADE`, 4: entries per requester FIFO; power of two, ≥2.
- `NUM_SAIDAS`, 3: number of valid display addresses (0..NUM_SAIDAS-1).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset (0 = reset).
- `req0_valid` in 1: CPU write request.
- `req0_ready` out 1: CPU FIFO can accept this cycle.
- `req0_endereco` in 32: CPU target display address.
- `req0_dado` in 32: CPU data.
- `req1_valid`, `req1_ready`, `req1_endereco`, `req1_dado`: same as above, for the debug requester.
- `OUT` out 1: write strobe to the output unit.
- `endereco` out 32: address to the output unit.
- `dado_de_saida` out 32: data to the output unit.
- `ocupado` out 1: either FIFO non-empty or `OUT` high.
- `erro_endereco` out 1: sticky; an invalid address was dropped.
- `origem_erro` out 1: requester index of the first dropped write.

## Operation
- Handshake:
  - A request is accepted on a rising edge when `reqN_valid & reqN_ready`.
  - `reqN_ready` = FIFO N not full; it is combinational from registered occupancy only, never from `valid`.
  - Once asserted, `valid` need not be held; each accepted beat is one entry.
- FIFO: circular buffer, write and read pointers of log2(PROFUNDIDADE)+1 bits.
  - Full = pointers differ only in MSB.
  - Empty = pointers equal.
  - Pointers wrap naturally.
- Arbitration: evaluated every cycle among non-empty FIFOs.
  - If exactly one is non-empty, it is granted.
  - If both are non-empty, the requester not granted last wins.
  - The last-grant pointer `ultimo` resets to 1, so requester 0 wins the first tie.
  - Exactly one entry is popped per grant.
- Issue: the granted head entry is loaded into the output registers on the edge that pops it.
  - If `endereco < NUM_SAIDAS` (full 32-bit unsigned compare): `OUT`←1, `endereco`/`dado_de_saida` ← entry.
  - Otherwise: `OUT`←0, the entry is discarded, and `erro_endereco`←1. `origem_erro` is loaded only if `erro_endereco` was 0.
  - An invalid entry still consumes the grant and updates `ultimo`.
- No grant in a cycle: `OUT`←0. `endereco`/`dado_de_saida` hold their last value.
- `erro_endereco` clears only on reset.
- Per-requester ordering is preserved. There is no ordering guarantee across requesters.

## Timing
- Reset (`reset`=0 at an edge):
  - FIFOs emptied; pending writes are lost.
  - `OUT`=0, `endereco`=0, `dado_de_saida`=0, `erro_endereco`=0, `origem_erro`=0, `ultimo`=1.
  - `reqN_ready`=1 from the first cycle after reset.
  - Reset wins over any simultaneous push or pop.
- Latency: request accepted at edge N → entry is poppable in cycle N..N+1 → popped and loaded at edge N+1 → `OUT`=1 during cycle N+1..N+2 → output unit captures at edge N+2.
- Throughput: one write per cycle total, sustained. With both FIFOs non-empty, grants strictly alternate 0,1,0,1.
- Simultaneous push and pop on the same FIFO:
  - Allowed when not full; occupancy is unchanged.
  - When full, `ready`=0, so push is impossible; the pop frees a slot and `ready` rises the next cycle.
- Push into an empty FIFO cannot be popped in the same cycle (no bypass).
- `OUT` is high for exactly one cycle per valid entry. Back-to-back writes keep `OUT` high continuously, with new address/data each cycle.

## Structure
- Shared package `saida_pkg`:
  - `NUM_SAIDAS_PADRAO`=3, `PROFUNDIDADE_PADRAO`=4.
  - Requester index constants `REQ_CPU`=0, `REQ_DEBUG`=1.
  - Entry struct {endereco[31:0], dado[31:0]}.
- Sub-module `fifo_saida`: parameterized FIFO with push/pop/full/empty, instantiated twice.
- Arbiter, range check and output registers live in the top level.

## Test plan
- Reset with `reset`=0 while both FIFOs hold 2 entries → after release: `OUT`=0, `ocupado`=0, both `ready`=1, and no stale writes ever appear.
- Single CPU write (addr 1, data 0xDEADBEEF) accepted at edge N → `OUT`=1 with endereco=1, data=0xDEADBEEF exactly during cycle N+1..N+2, then `OUT`=0.
- Both requesters push 3 entries (A0..A2, B0..B2) in the same cycles → `OUT` sequence A0,B0,A1,B1,A2,B2, on consecutive cycles with no gaps.
- CPU pushes 5 writes back-to-back with no contention, `PROFUNDIDADE`=4:
  - `req0_ready` stays 1 throughout, since the FIFO drains while filling and never reaches full.
  - With requester 1 continuously competing, `req0_ready` drops to 0 once 4 entries are held and recovers one cycle after a pop.
- Debug write to addr 3, then CPU write to addr 0 (data 7) → no `OUT` for addr 3; `erro_endereco`=1, `origem_erro`=1; the addr 0 write is issued normally. A later invalid write from the CPU leaves `origem_erro`=1.
- Address 0x0000_0100 (high bits set) → rejected as invalid. Address 2 → accepted.
